// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler fetch sequencer: state encoding,
// jump-class opcodes, default widths and the jump-class decode helper.
package nibbler_pkg;

    localparam int NIBBLER_ADDR_W  = 12;
    localparam int NIBBLER_INSTR_W = 8;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_OPERAND = 2'd1,
        S_JUMP    = 2'd2,
        S_EXEC    = 2'd3
    } seqState_e;

    localparam logic [3:0] OP_JC  = 4'h0;
    localparam logic [3:0] OP_JNC = 4'h1;
    localparam logic [3:0] OP_JZ  = 4'h2;
    localparam logic [3:0] OP_JNZ = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;

    // Jump opcodes occupy the contiguous range 0x0..0x4.
    function automatic logic isJump(input logic [3:0] opcode);
        return (opcode <= OP_JMP);
    endfunction

endpackage

// File: rtl/nibbler_jump_condition.sv
// Combinational jump resolution: decides whether a jump-class opcode is taken
// given the ALU carry and zero flags. Non-jump opcodes are never taken.
module nibbler_jump_condition
    import nibbler_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       carry,
    input  logic       zero,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_JC:   taken = carry;
            OP_JNC:  taken = ~carry;
            OP_JZ:   taken = zero;
            OP_JNZ:  taken = ~zero;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/nibbler_fetch_sequencer.sv
// Fetch/jump sequencer driving the Nibbler PC controls and execute strobe.
// Optional freeze input is built when NIBBLER_FETCH_HALT_EN is defined.
module nibbler_fetch_sequencer
    import nibbler_pkg::*;
#(
    parameter int ADDR_W  = NIBBLER_ADDR_W,
    parameter int INSTR_W = NIBBLER_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] romData,
    input  logic               carryFlag,
    input  logic               zeroFlag,
`ifdef NIBBLER_FETCH_HALT_EN
    input  logic               halt,
`endif
    output logic               incPC,
    output logic               notLoadPC,
    output logic               pcNotReset,
    output logic [ADDR_W-1:0]  addressIn,
    output logic [INSTR_W-1:0] instruction,
    output logic               execStrobe,
    output logic [1:0]         phase
);

    seqState_e          state, stateNext;
    logic               incReg, incNext;
    logic               notLoadReg, notLoadNext;
    logic               strobeReg, strobeNext;
    logic [ADDR_W-1:0]  addrReg, addrNext;
    logic [INSTR_W-1:0] instrReg, instrNext;
    logic               pcNotResetReg;
    logic               taken;

    nibbler_jump_condition u_jumpCondition (
        .opcode (instrReg[7:4]),
        .carry  (carryFlag),
        .zero   (zeroFlag),
        .taken  (taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_FETCH;
            incReg        <= 1'b0;
            notLoadReg    <= 1'b1;
            strobeReg     <= 1'b0;
            addrReg       <= '0;
            instrReg      <= '0;
            pcNotResetReg <= 1'b0;
        end else begin
            state         <= stateNext;
            incReg        <= incNext;
            notLoadReg    <= notLoadNext;
            strobeReg     <= strobeNext;
            addrReg       <= addrNext;
            instrReg      <= instrNext;
            pcNotResetReg <= 1'b1;
        end
    end

    // Pulse outputs default to idle so each is high for exactly one cycle.
    always_comb begin
        stateNext   = state;
        incNext     = 1'b0;
        notLoadNext = 1'b1;
        strobeNext  = 1'b0;
        addrNext    = addrReg;
        instrNext   = instrReg;
        case (state)
            S_FETCH: begin
                instrNext = romData;
                incNext   = 1'b1;
                stateNext = isJump(romData[7:4]) ? S_OPERAND : S_EXEC;
            end
            S_OPERAND: begin
                addrNext  = ADDR_W'({instrReg[3:0], romData});
                incNext   = 1'b1;
                stateNext = S_JUMP;
            end
            S_JUMP: begin
                notLoadNext = ~taken;
                stateNext   = S_FETCH;
            end
            S_EXEC: begin
                strobeNext = 1'b1;
                stateNext  = S_FETCH;
            end
            default: stateNext = S_FETCH;
        endcase
`ifdef NIBBLER_FETCH_HALT_EN
        if (halt) begin
            stateNext   = state;
            incNext     = incReg;
            notLoadNext = notLoadReg;
            strobeNext  = strobeReg;
            addrNext    = addrReg;
            instrNext   = instrReg;
        end
`endif
    end

`ifdef NIBBLER_FETCH_HALT_EN
    // Registers keep their pending pulses while frozen; only the pins are masked.
    assign incPC      = incReg & ~halt;
    assign notLoadPC  = notLoadReg | halt;
    assign execStrobe = strobeReg & ~halt;
`else
    assign incPC      = incReg;
    assign notLoadPC  = notLoadReg;
    assign execStrobe = strobeReg;
`endif

    assign pcNotReset  = pcNotResetReg;
    assign addressIn   = addrReg;
    assign instruction = instrReg;
    assign phase       = state;

    noIncWithLoad: assert property (@(posedge clk) disable iff (reset) !(incPC && !notLoadPC));

endmodule

// File: tb/tb_nibbler_fetch_sequencer.sv
// Directed bench for nibbler_fetch_sequencer with a behavioural PC + ROM and an
// expected-value scoreboard for execute strobes and PC loads.
module tb_nibbler_fetch_sequencer;
    import nibbler_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  romData;
    logic        carryFlag;
    logic        zeroFlag;
`ifdef NIBBLER_FETCH_HALT_EN
    logic        halt;
`endif
    logic        incPC;
    logic        notLoadPC;
    logic        pcNotReset;
    logic [11:0] addressIn;
    logic [7:0]  instruction;
    logic        execStrobe;
    logic [1:0]  phase;

    logic [7:0]  rom [0:4095];
    logic [11:0] pc;
    logic [7:0]  exp_q[$];
    logic [11:0] load_q[$];
    int          passCount = 0;
    int          checkCount = 0;

    nibbler_fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .romData     (romData),
        .carryFlag   (carryFlag),
        .zeroFlag    (zeroFlag),
`ifdef NIBBLER_FETCH_HALT_EN
        .halt        (halt),
`endif
        .incPC       (incPC),
        .notLoadPC   (notLoadPC),
        .pcNotReset  (pcNotReset),
        .addressIn   (addressIn),
        .instruction (instruction),
        .execStrobe  (execStrobe),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    // PC model advances mid-cycle so the ROM byte is settled at the next sequencer edge.
    always @(negedge clk) begin
        if (!pcNotReset)     pc <= 12'h000;
        else if (!notLoadPC) pc <= addressIn;
        else if (incPC)      pc <= pc + 12'h001;
    end
    assign romData = rom[pc];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock; then score any strobe or load the DUT produced this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (execStrobe === 1'b1) begin
            check("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("strobe_instr", 32'(instruction), 32'(exp_q.pop_front()));
        end
        if (notLoadPC === 1'b0) begin
            check("load_expected", 32'(load_q.size() > 0), 32'd1);
            if (load_q.size() > 0) check("load_addr", 32'(addressIn), 32'(load_q.pop_front()));
        end
        if (incPC === 1'b1 && notLoadPC === 1'b0) check("inc_and_load", 32'd1, 32'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        carryFlag = 1'b0;
        zeroFlag = 1'b0;
`ifdef NIBBLER_FETCH_HALT_EN
        halt = 1'b0;
`endif
        repeat (3) tick();
        check("rst_incPC", 32'(incPC), 32'd0);
        check("rst_notLoadPC", 32'(notLoadPC), 32'd1);
        check("rst_pcNotReset", 32'(pcNotReset), 32'd0);
        check("rst_execStrobe", 32'(execStrobe), 32'd0);
        check("rst_phase", 32'(phase), 32'(S_FETCH));
        check("rst_instruction", 32'(instruction), 32'd0);
        check("rst_addressIn", 32'(addressIn), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("rst_load_q_empty", 32'(load_q.size()), 32'd0);
        for (int i = 0; i < 4096; i++) rom[i] = 8'h70;
    endtask

    initial begin
        // Test 1+2: reset values, then a single-byte instruction.
        doReset();
        rom[12'h000] = 8'h5A;
        exp_q.push_back(8'h5A);
        reset = 1'b0;
        tick();
        check("t1_first_incPC", 32'(incPC), 32'd1);
        check("t1_pcNotReset", 32'(pcNotReset), 32'd1);
        check("t2_phase_exec", 32'(phase), 32'(S_EXEC));
        tick();
        check("t2_strobe", 32'(execStrobe), 32'd1);
        check("t2_pc", 32'(pc), 32'h001);
        tick();
        check("t2_strobe_one_cycle", 32'(execStrobe), 32'd0);

        // Test 3: unconditional jump to 0x321.
        doReset();
        rom[12'h000] = 8'h43;
        rom[12'h001] = 8'h21;
        rom[12'h321] = 8'h5B;
        load_q.push_back(12'h321);
        exp_q.push_back(8'h5B);
        reset = 1'b0;
        tick();
        check("t3_phase_operand", 32'(phase), 32'(S_OPERAND));
        tick();
        check("t3_phase_jump", 32'(phase), 32'(S_JUMP));
        check("t3_addressIn", 32'(addressIn), 32'h321);
        tick();
        check("t3_load_low", 32'(notLoadPC), 32'd0);
        tick();
        check("t3_load_one_cycle", 32'(notLoadPC), 32'd1);
        check("t3_pc", 32'(pc), 32'h321);
        check("t3_instruction", 32'(instruction), 32'h5B);
        tick();

        // Test 4a: JC not taken; carry high outside S_JUMP must be ignored.
        doReset();
        rom[12'h000] = 8'h0A;
        rom[12'h001] = 8'h55;
        rom[12'h002] = 8'h5C;
        exp_q.push_back(8'h5C);
        carryFlag = 1'b1;
        reset = 1'b0;
        tick();
        tick();
        carryFlag = 1'b0;
        tick();
        check("t4a_no_load", 32'(notLoadPC), 32'd1);
        check("t4a_pc", 32'(pc), 32'h002);
        check("t4a_addressIn", 32'(addressIn), 32'hA55);
        tick();
        carryFlag = 1'b1;
        tick();

        // Test 4b: JC taken.
        doReset();
        rom[12'h000] = 8'h0A;
        rom[12'h001] = 8'h55;
        rom[12'hA55] = 8'h5D;
        load_q.push_back(12'hA55);
        exp_q.push_back(8'h5D);
        reset = 1'b0;
        tick();
        tick();
        carryFlag = 1'b1;
        tick();
        carryFlag = 1'b0;
        tick();
        check("t4b_pc", 32'(pc), 32'hA55);
        tick();

        // JZ to 0xFFF, where a JMP's operand wraps around to address 0x000.
        doReset();
        rom[12'h000] = 8'h2F;
        rom[12'h001] = 8'hFF;
        rom[12'hFFF] = 8'h46;
        rom[12'h62F] = 8'h5E;
        load_q.push_back(12'hFFF);
        load_q.push_back(12'h62F);
        exp_q.push_back(8'h5E);
        zeroFlag = 1'b1;
        reset = 1'b0;
        repeat (4) tick();
        check("wrap_instruction", 32'(instruction), 32'h46);
        tick();
        check("wrap_addressIn", 32'(addressIn), 32'h62F);
        repeat (2) tick();
        check("wrap_pc", 32'(pc), 32'h62F);
        tick();

        // Test 5: reset during S_OPERAND aborts the jump.
        doReset();
        rom[12'h000] = 8'h43;
        rom[12'h001] = 8'h21;
        reset = 1'b0;
        tick();
        check("t5_phase_operand", 32'(phase), 32'(S_OPERAND));
        reset = 1'b1;
        repeat (3) begin
            tick();
            check("t5_no_load", 32'(notLoadPC), 32'd1);
        end
        check("t5_phase_fetch", 32'(phase), 32'(S_FETCH));
        reset = 1'b0;
        tick();
        check("t5_refetch", 32'(instruction), 32'h43);
        check("t5_phase_after", 32'(phase), 32'(S_OPERAND));

`ifdef NIBBLER_FETCH_HALT_EN
        // Test 6: halt in S_EXEC freezes everything; exactly one strobe afterwards.
        doReset();
        rom[12'h000] = 8'h5A;
        exp_q.push_back(8'h5A);
        reset = 1'b0;
        tick();
        halt = 1'b1;
        #1;
        check("t6_inc_masked", 32'(incPC), 32'd0);
        repeat (4) begin
            tick();
            check("t6_strobe_held", 32'(execStrobe), 32'd0);
            check("t6_inc_held", 32'(incPC), 32'd0);
            check("t6_phase_held", 32'(phase), 32'(S_EXEC));
            check("t6_pc_held", 32'(pc), 32'h000);
        end
        halt = 1'b0;
        #1;
        check("t6_inc_resume", 32'(incPC), 32'd1);
        tick();
        check("t6_strobe", 32'(execStrobe), 32'd1);
        check("t6_pc", 32'(pc), 32'h001);
        tick();
        check("t6_strobe_once", 32'(execStrobe), 32'd0);
`endif

        reset = 1'b1;
        tick();
        check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("end_load_q_empty", 32'(load_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
